// File: rtl/if_stage.sv
// Instruction fetch stage: latches the PC, issues one memory read,
// and holds the fetched word until decode takes it.
module if_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              flush,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic capture;
  logic accept;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = HOLD;
      HOLD:    if (inst_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // flush suppresses both a late ack and a decode handshake
  assign capture = (state == REQ) && imem_ack && !flush;
  assign accept  = (state == HOLD) && inst_ready && !flush;

  assign pc_stall   = (state != IDLE);
  assign imem_req   = (state == REQ);
  assign inst_valid = (state == HOLD);
  assign imem_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      inst_out    <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) addr_q <= pc_in;
      if (capture) begin
        inst_out <= imem_rdata;
        inst_pc  <= addr_q;
      end
      if (accept) fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an expected-instruction queue
// checked at each decode handshake.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_in;
  logic        pc_stall;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [7:0]  inst_pc;
  logic        flush;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic [39:0] sb_q[$];
  logic [15:0] exp_count;
  logic [31:0] last_inst;

  if_stage #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .pc_stall(pc_stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .flush(flush),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; ends at a negedge back in IDLE.
  task automatic do_fetch(input logic [7:0] pc, input logic [31:0] data,
                          input int ack_dly, input int rdy_dly);
    logic [39:0] e;
    pc_in = pc;
    sb_q.push_back({data, pc});
    @(negedge clk);
    pc_in = 8'h5A;
    for (int i = 0; i <= ack_dly; i++) begin
      chk("req", imem_req, 1);
      chk("addr", imem_addr, pc);
      chk("stall", pc_stall, 1);
      chk("valid_in_req", inst_valid, 0);
      if (i == ack_dly) begin
        imem_ack = 1'b1;
        imem_rdata = data;
      end
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'h0BAD_0BAD;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("valid_hold", inst_valid, 1);
      chk("req_hold", imem_req, 0);
      chk("stall_hold", pc_stall, 1);
      chk("count_hold", fetch_count, exp_count);
      if (i == rdy_dly) begin
        e = sb_q.pop_front();
        chk("inst_out", inst_out, e[39:8]);
        chk("inst_pc", inst_pc, e[7:0]);
        inst_ready = 1'b1;
      end else begin
        chk("out_stable", inst_out, data);
        chk("pc_stable", inst_pc, pc);
      end
      @(negedge clk);
      inst_ready = 1'b0;
    end
    exp_count = exp_count + 16'd1;
    last_inst = data;
    chk("count_inc", fetch_count, exp_count);
    chk("valid_idle", inst_valid, 0);
    chk("stall_idle", pc_stall, 0);
  endtask

  initial begin
    reset = 1'b1;
    pc_in = 8'h00;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    flush = 1'b0;
    exp_count = 16'h0;
    last_inst = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_stall", pc_stall, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_count", fetch_count, 0);
    reset = 1'b0;

    do_fetch(8'h00, 32'h0000_0013, 0, 0);
    do_fetch(8'h24, 32'h1234_5678, 4, 0);
    do_fetch(8'h38, 32'hCAFE_F00D, 0, 3);

    // flush together with ack must drop the word
    pc_in = 8'h40;
    @(negedge clk);
    chk("fl_req", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    flush = 1'b0;
    chk("fl_valid", inst_valid, 0);
    chk("fl_req_idle", imem_req, 0);
    chk("fl_stall", pc_stall, 0);
    chk("fl_out", inst_out, last_inst);
    chk("fl_count", fetch_count, exp_count);

    do_fetch(8'h44, 32'h0040_0093, 1, 1);

    // reset while holding an instruction
    pc_in = 8'h50;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mid_valid", inst_valid, 1);
    reset = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    exp_count = 16'h0;
    chk("mr_req", imem_req, 0);
    chk("mr_valid", inst_valid, 0);
    chk("mr_stall", pc_stall, 0);
    chk("mr_addr", imem_addr, 0);
    chk("mr_pc", inst_pc, 0);
    chk("mr_out", inst_out, 0);
    chk("mr_count", fetch_count, 0);

    do_fetch(8'hFF, 32'hFFFF_0001, 0, 0);

    // preset the counter near the top, then cross the wrap
    force dut.fetch_count = 16'hFFFE;
    #1;
    release dut.fetch_count;
    exp_count = 16'hFFFE;
    chk("preset", fetch_count, 16'hFFFE);
    do_fetch(8'h10, 32'h0000_0001, 0, 0);
    chk("at_max", fetch_count, 16'hFFFF);
    do_fetch(8'h14, 32'h0000_0002, 0, 0);
    chk("wrapped", fetch_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the width of the PC and instruction-memory address.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of the instruction word.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 pc_in  input  ADDR_W  SHALL carry the current address from the PC stage.
REQ-006 pc_stall  output  1  SHALL signal the PC stage to hold its value.
REQ-007 imem_req  output  1  SHALL request an instruction-memory read.
REQ-008 imem_addr  output  ADDR_W  SHALL carry the read address.
REQ-009 imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-010 imem_rdata  input  DATA_W  SHALL carry the read data.
REQ-011 inst_valid  output  1  SHALL indicate that inst_out and inst_pc hold a fetched instruction.
REQ-012 inst_ready  input  1  SHALL indicate that decode accepts the instruction.
REQ-013 inst_out  output  DATA_W  SHALL carry the fetched instruction.
REQ-014 inst_pc  output  ADDR_W  SHALL carry the address of inst_out.
REQ-015 flush  input  1  SHALL discard any in-flight fetch.
REQ-016 fetch_count  output  16  SHALL count accepted instructions.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, REQ and HOLD.
REQ-018 In IDLE, the block SHALL latch pc_in into the address register, drive pc_stall=0 and go to REQ on the next edge.
REQ-019 In REQ, imem_req SHALL be 1, imem_addr SHALL equal the latched address and stay stable, and pc_stall SHALL be 1.
REQ-020 In REQ with imem_ack=1, the block SHALL capture imem_rdata into inst_out and the address into inst_pc, and go to HOLD.
REQ-021 In REQ with imem_ack=0, the block SHALL stay in REQ with no timeout.
REQ-022 In HOLD, inst_valid SHALL be 1, imem_req SHALL be 0, pc_stall SHALL be 1, and inst_out and inst_pc SHALL be stable.
REQ-023 In HOLD with inst_ready=1, the block SHALL go to IDLE; otherwise it SHALL stay in HOLD.
REQ-024 In every state other than HOLD, inst_valid SHALL be 0.
REQ-025 Latency: with pc_in sampled at edge N and imem_ack high during cycle N+1, inst_valid SHALL be high during cycle N+2; the minimum issue interval SHALL be 3 cycles.
REQ-026 imem_ack SHALL be ignored in IDLE and HOLD.
REQ-027 flush=1 SHALL force IDLE on the next edge from any state and clear inst_valid.
REQ-028 An imem_ack in the same cycle as flush SHALL be discarded, with inst_out unchanged.
REQ-029 flush SHALL take priority over imem_ack and inst_ready; reset SHALL take priority over flush.
REQ-030 fetch_count SHALL increment by 1 on each edge where inst_valid=1 and inst_ready=1.
REQ-031 fetch_count SHALL wrap from 0xFFFF to 0x0000.
REQ-032 Address 0xFF SHALL be fetched normally; address arithmetic is not performed here, so no wrap handling is needed.

Reset
REQ-033 While reset=1 at an edge, the FSM SHALL go to IDLE.
REQ-034 On reset, imem_req, inst_valid and pc_stall SHALL be 0; imem_addr, inst_pc and fetch_count SHALL be 0; inst_out SHALL be 0.
REQ-035 Reset asserted during REQ or HOLD SHALL abandon the fetch; an ack in the reset cycle SHALL be ignored.
REQ-036 The first fetch after reset release SHALL sample pc_in in the first cycle with reset=0.

Verification
REQ-037 Basic fetch: reset 1 cycle, pc_in=0x00, imem_ack=1 in the REQ cycle with rdata=0x00000013, inst_ready=1 -> inst_valid for 1 cycle with inst_out=0x00000013, inst_pc=0x00, fetch_count=1.
REQ-038 Memory wait: imem_ack delayed 4 cycles -> imem_req held 5 cycles with constant imem_addr, pc_stall=1 throughout, inst_valid only after the ack.
REQ-039 Decode backpressure: inst_ready=0 for 3 cycles in HOLD -> inst_out and inst_pc stable, fetch_count unchanged until inst_ready=1, then +1.
REQ-040 Flush: flush in the REQ cycle together with imem_ack (rdata=0xDEADBEEF) -> IDLE next cycle, inst_valid never asserted, inst_out not 0xDEADBEEF.
REQ-041 Reset mid-operation: reset in HOLD with inst_ready=0 -> next cycle all outputs are 0 and the state is IDLE.
REQ-042 Boundary: pc_in=0xFF fetched correctly (inst_pc=0xFF); fetch_count preset by 65535 handshakes, then one more -> 0x0000.
